sha_mem_arbiter: RTL
====================

// Module: sha_mem_arbiter
// PURPOSE
//  Shares the single synchronous memory port among NUM_REQ simplified_sha256 hashers.
//  Grants are job-level: a hasher owns the port from grant until it drops req, so its
//  fixed 1-cycle read latency is never disturbed. Round-robin between jobs, with one
//  idle turnaround cycle. Sits between the hasher array and the testbench/top memory.
// PARAMETERS
//  NUM_REQ  4   number of requesting hashers (2..8)
//  ADDR_W   16  memory address width
//  DATA_W   32  memory data width
// PORTS
//  clk             in   1                 system clock; also drives mem_clk
//  reset           in   1                 asynchronous, active-high reset
//  req             in   NUM_REQ           per-hasher job request; held high for whole job
//  req_we          in   NUM_REQ           per-hasher write enable
//  req_addr        in   NUM_REQ*ADDR_W    per-hasher address, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata       in   NUM_REQ*DATA_W    per-hasher write data, same packing
//  gnt             out  NUM_REQ           one-hot (or zero) grant, registered
//  req_rdata       out  DATA_W            mem_read_data broadcast to all requesters
//  busy            out  1                 port owned (gnt != 0)
//  owner           out  $clog2(NUM_REQ)   index of current/last owner
//  mem_clk         out  1                 = clk
//  mem_we          out  1                 to memory
//  mem_addr        out  ADDR_W            to memory
//  mem_write_data  out  DATA_W            to memory
//  mem_read_data   in   DATA_W            from memory
// BEHAVIOUR
//  Reset (async, while asserted): state=IDLE, gnt=0, busy=0, owner=0, rr_ptr=0;
//   mem_we=0, mem_addr=0, mem_write_data=0 combinationally (no stray write mid-job).
//  FSM states: IDLE, OWN, TURN.
//   IDLE: if any req, pick winner w = first set bit of req scanning from rr_ptr upward
//     with wrap; next edge: gnt<=1<<w, owner<=w, state<=OWN. No req: stay IDLE.
//   OWN: while req[owner]=1 stay. When req[owner]=0: next edge gnt<=0, state<=TURN,
//     rr_ptr<=owner+1 (wrap to 0 at NUM_REQ).
//   TURN: memory idle this cycle. Arbitrate as in IDLE using updated rr_ptr; winner
//     granted on next edge (state<=OWN), else state<=IDLE.
//  Latency: req rise in IDLE at cycle t -> gnt visible cycle t+1.
//   Owner drops req cycle t -> gnt low t+1 (TURN) -> next gnt visible t+2.
//  Memory mux (combinational from registered owner/gnt): in OWN, mem_* = owner's
//   req_we/req_addr/req_wdata same cycle (no added latency). In IDLE/TURN, mem_we=0,
//   mem_addr=0, mem_write_data=0. req_rdata = mem_read_data always.
//  Ungranted requester signals are ignored entirely; req may drop before grant
//   (withdrawal) with no effect. req_we from owner while req[owner]=0 is ignored.
//  Simultaneous owner release and new requests: handled by TURN; releasing owner has
//   lowest priority next round (rr_ptr past it). Owner re-raising req in TURN competes
//   normally.
//  No preemption and no timeout: a hung owner holds the port indefinitely.
//  gnt is never multi-hot; busy = |gnt.
// TESTING
//  Reset pulse mid-job (req[1] owner, req_we=1) -> gnt=0, mem_we=0 during reset; owner=0.
//  req=4'b0001 single job, addr 0x0010..0x001F -> gnt[0] next cycle; mem_addr tracks
//   req_addr[0] same cycle; req drop -> one cycle mem_we=0, back to IDLE.
//  req=4'b1111 held, each drops after 20 cycles then stays low -> grants 0,1,2,3 in
//   order, exactly 1 TURN cycle between jobs, no multi-hot gnt.
//  Owner 2 drops while req=4'b0101 -> next grant to 0 (wrap past 3), not 2.
//  req[3] pulses 1 cycle while 0 owns -> never granted; mem_* never reflects
//   requester 3.
//  Two simplified_sha256 on ports 0/1, message_addr 0 / 0x40 -> both digests match the
//   golden SHA-256 values at their output addresses.

Source files
------------

// File: rtl/sha_mem_arbiter_if.sv
// Hasher-array and memory-side bus shared by the arbiter and its environment.
interface sha_mem_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         req_rdata;
    logic                      busy;
    logic [OWN_W-1:0]          owner;
    logic                      mem_clk;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_write_data;
    logic [DATA_W-1:0]         mem_read_data;

    // Arbiter side.
    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_read_data,
        output gnt, req_rdata, busy, owner, mem_clk, mem_we, mem_addr, mem_write_data
    );

    // Environment side: hashers plus memory.
    modport master (
        output req, req_we, req_addr, req_wdata, mem_read_data,
        input  gnt, req_rdata, busy, owner, mem_clk, mem_we, mem_addr, mem_write_data
    );
endinterface

// File: rtl/sha_mem_arbiter.sv
// Job-level round-robin arbiter sharing one synchronous memory port among hashers.
module sha_mem_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    sha_mem_arbiter_if.slave    bus
);
    localparam int unsigned OWN_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] gnt, gnt_n;
    logic [OWN_W-1:0]   owner, owner_n;
    logic [OWN_W-1:0]   rr_ptr, rr_ptr_n;
    logic               busy, busy_n;
    logic [OWN_W-1:0]   win;
    logic               any_req;

    // State register plus registered grant/owner/pointer outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            owner  <= owner_n;
            rr_ptr <= rr_ptr_n;
            busy   <= busy_n;
        end
    end

    // Round-robin pick: first requester at or above rr_ptr, wrapping.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned idx;
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req && bus.req[OWN_W'(idx)]) begin
                any_req = 1'b1;
                win     = OWN_W'(idx);
            end
        end
    end

    // Next-state: grant from IDLE/TURN, hold for whole job, one turnaround on release.
    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        unique case (state)
            IDLE, TURN: begin
                if (any_req) begin
                    state_n = OWN;
                    gnt_n   = NUM_REQ'(1) << win;
                    owner_n = win;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
            end
            OWN: begin
                if (!bus.req[owner]) begin
                    state_n  = TURN;
                    gnt_n    = '0;
                    rr_ptr_n = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + OWN_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
        busy_n = |gnt_n;
    end

    // Memory mux: owner's request passes straight through only while in OWN.
    always_comb begin
        bus.mem_we         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
        if (state == OWN) begin
            bus.mem_we         = bus.req_we[owner] & bus.req[owner];
            bus.mem_addr       = bus.req_addr[32'(owner) * ADDR_W +: ADDR_W];
            bus.mem_write_data = bus.req_wdata[32'(owner) * DATA_W +: DATA_W];
        end
    end

    assign bus.gnt       = gnt;
    assign bus.owner     = owner;
    assign bus.busy      = busy;
    assign bus.mem_clk   = clk;
    assign bus.req_rdata = bus.mem_read_data;

endmodule
